// File: rtl/pcileech_ft601_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_ft601_pkg
//   Shared definitions for the FT601 receive/transmit buffering chain:
//   the host filler dword, the 256-bit word geometry, the receive packer
//   state encoding and a helper that pads a partial word with filler.
// -----------------------------------------------------------------------------
package pcileech_ft601_pkg;

    // Filler dword the host inserts to pad its transfers.
    localparam logic [31:0] FT601_MAGIC_DWORD = 32'h66665555;

    localparam int DWORDS_PER_WORD = 8;
    // Wide enough to count 0..DWORDS_PER_WORD inclusive.
    localparam int IDX_W = $clog2(DWORDS_PER_WORD + 1);

    typedef logic [DWORDS_PER_WORD-1:0][31:0] dword_word_t;

    typedef enum logic [1:0] {
        EMPTY,  // accumulator holds no dwords
        FILL,   // accumulator holds 1..7 dwords
        FULL    // accumulator holds 8 dwords, waiting for the output register
    } rx_pack_state_e;

    // Keep slots 0..cnt-1 of acc, replace the rest with the filler value.
    function automatic dword_word_t pad_word(input dword_word_t      acc,
                                             input logic [IDX_W-1:0] cnt,
                                             input logic [31:0]      magic);
        dword_word_t w;
        for (int k = 0; k < DWORDS_PER_WORD; k++) begin
            w[k] = (k < int'(cnt)) ? acc[k] : magic;
        end
        return w;
    endfunction

endpackage

// File: rtl/pcileech_ft601_rx_packer_if.sv
// -----------------------------------------------------------------------------
// pcileech_ft601_rx_packer_if
//   Bundles the dword input stream from the FT601 controller and the packed
//   256-bit valid/ready output toward the FIFO controller.
//   master : the packer (consumes rx_*, produces dout*)
//   slave  : the surrounding logic (produces rx_*, consumes dout*)
// -----------------------------------------------------------------------------
interface pcileech_ft601_rx_packer_if;
    import pcileech_ft601_pkg::*;

    logic [31:0]      rx_data;
    logic             rx_wren;
    logic [255:0]     dout;
    logic [IDX_W-1:0] dout_cnt;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        input  rx_data, rx_wren, dout_ready,
        output dout, dout_cnt, dout_valid
    );

    modport slave (
        output rx_data, rx_wren, dout_ready,
        input  dout, dout_cnt, dout_valid
    );

endinterface

// File: rtl/pcileech_rx_out_reg.sv
// -----------------------------------------------------------------------------
// pcileech_rx_out_reg
//   Single-entry valid/ready output register for packed words.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     load                capture load_data/load_cnt (only issued when free)
//     load_data, load_cnt word and its real dword count
//     ready               downstream accepts the held word
//     data, cnt, valid    held word, count and valid flag
//     free                register can take a new word this cycle
// -----------------------------------------------------------------------------
module pcileech_rx_out_reg
    import pcileech_ft601_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [255:0]     load_data,
    input  logic [IDX_W-1:0] load_cnt,
    input  logic             ready,
    output logic [255:0]     data,
    output logic [IDX_W-1:0] cnt,
    output logic             valid,
    output logic             free
);

    // Empty, or the held word leaves on this same edge.
    assign free = ~valid | ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            cnt   <= load_cnt;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pcileech_ft601_rx_packer.sv
// -----------------------------------------------------------------------------
// pcileech_ft601_rx_packer
//   Packs the FT601 controller's 32-bit dword stream into 256-bit words.
//   Host filler dwords are optionally dropped; a partial word is flushed,
//   padded with filler, after TIMEOUT_CYCLES idle cycles.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     bus (master)   rx_data/rx_wren in, dout/dout_cnt/dout_valid/dout_ready out
//     overflow       sticky: a dword was lost with accumulator and output full
//     magic_dropped  saturating count of filtered filler dwords
// -----------------------------------------------------------------------------
module pcileech_ft601_rx_packer
    import pcileech_ft601_pkg::*;
#(
    parameter logic [31:0] MAGIC_DWORD    = FT601_MAGIC_DWORD,
    parameter bit          FILTER_MAGIC   = 1'b1,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    pcileech_ft601_rx_packer_if.master    bus,
    output logic                          overflow,
    output logic [15:0]                   magic_dropped
);

    localparam logic [15:0]      IDLE_MAX = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DWORDS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DWORDS_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    rx_pack_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      idle_q, idle_d;
    dword_word_t      acc_q;

    logic             is_filtered;
    logic             is_data;
    logic             accept;
    logic             out_free;
    logic             load;
    dword_word_t      load_data;
    logic [IDX_W-1:0] load_cnt;
    dword_word_t      acc_plus_new;

    assign is_filtered = bus.rx_wren && FILTER_MAGIC && (bus.rx_data == MAGIC_DWORD);
    assign is_data     = bus.rx_wren && !is_filtered;
    assign accept      = is_data && (state_q != FULL);

    // Accumulator with the incoming dword already in its slot, so the 8th
    // dword can go straight to the output register on the edge it arrives.
    always_comb begin
        acc_plus_new = acc_q;
        acc_plus_new[DWORDS_PER_WORD-1] = bus.rx_data;
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        idle_d    = idle_q;
        load      = 1'b0;
        load_data = acc_q;
        load_cnt  = IDX_FULL;

        unique case (state_q)
            EMPTY: begin
                idle_d = '0;
                if (accept) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    idle_d = '0;
                    if (idx_q == IDX_LAST) begin
                        if (out_free) begin
                            load      = 1'b1;
                            load_data = acc_plus_new;
                            idx_d     = '0;
                            state_d   = EMPTY;
                        end else begin
                            idx_d   = IDX_FULL;
                            state_d = FULL;
                        end
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    // Timed out: flush when possible, otherwise keep the
                    // counter saturated and retry every cycle.
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = pad_word(acc_q, idx_q, MAGIC_DWORD);
                        load_cnt  = idx_q;
                        idx_d     = '0;
                        idle_d    = '0;
                        state_d   = EMPTY;
                    end
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end

            FULL: begin
                if (out_free) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    idle_d  = '0;
                    state_d = EMPTY;
                end
            end

            default: begin
                idx_d   = '0;
                idle_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            idx_q         <= '0;
            idle_q        <= '0;
            overflow      <= 1'b0;
            magic_dropped <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            // A data dword arriving in FULL is lost, even on the cycle the
            // accumulator drains into the output register.
            if (is_data && (state_q == FULL)) begin
                overflow <= 1'b1;
            end
            if (is_filtered && (magic_dropped != 16'hFFFF)) begin
                magic_dropped <= magic_dropped + 16'd1;
            end
        end
    end

    // NOTE: the accumulator is plain storage with no reset; slots are always
    // written before they are read, and unwritten slots are replaced by
    // filler on a flush.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q[idx_q[2:0]] <= bus.rx_data;
        end
    end

    pcileech_rx_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_cnt  (load_cnt),
        .ready     (bus.dout_ready),
        .data      (bus.dout),
        .cnt       (bus.dout_cnt),
        .valid     (bus.dout_valid),
        .free      (out_free)
    );

endmodule

// File: tb/tb_pcileech_ft601_rx_packer.sv
// -----------------------------------------------------------------------------
// tb_pcileech_ft601_rx_packer
//   Directed cases with literal expectations plus randomized traffic, all
//   checked each cycle against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_pcileech_ft601_rx_packer;

    localparam logic [31:0] MAGIC   = 32'h66665555;
    localparam int          TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        overflow;
    logic [15:0] magic_dropped;

    pcileech_ft601_rx_packer_if bus ();

    pcileech_ft601_rx_packer #(
        .MAGIC_DWORD    (MAGIC),
        .FILTER_MAGIC   (1'b1),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .overflow      (overflow),
        .magic_dropped (magic_dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  m_pend[$];
    int           m_idle;
    bit           m_valid;
    logic [255:0] m_word;
    int           m_cnt;
    bit           m_ovf;
    int           m_drop;
    bit           m_live = 1'b0;

    function automatic logic [255:0] pack(input logic [31:0] q[$]);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            w[32*k +: 32] = (k < q.size()) ? q[k] : MAGIC;
        end
        return w;
    endfunction

    task automatic m_emit();
        m_word  = pack(m_pend);
        m_cnt   = m_pend.size();
        m_valid = 1'b1;
        m_pend.delete();
        m_idle  = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pend.delete();
            m_idle  = 0;
            m_valid = 1'b0;
            m_word  = '0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            bit free, is_mag, is_dat;
            free   = !m_valid || bus.dout_ready;
            is_mag = bus.rx_wren && (bus.rx_data == MAGIC);
            is_dat = bus.rx_wren && !is_mag;
            if (m_valid && bus.dout_ready) m_valid = 1'b0;
            if (is_mag && m_drop < 65535) m_drop++;
            if (m_pend.size() == 8) begin
                if (is_dat) m_ovf = 1'b1;
                if (free) m_emit();
            end else if (is_dat) begin
                m_pend.push_back(bus.rx_data);
                m_idle = 0;
                if (m_pend.size() == 8 && free) m_emit();
            end else if (m_pend.size() > 0) begin
                if (m_idle == TIMEOUT - 1) begin
                    if (free) m_emit();
                end else begin
                    m_idle++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + transfer counter ----------------
    int xfers = 0;

    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("model_valid", 256'(bus.dout_valid), 256'(m_valid));
            if (m_valid) begin
                check("model_dout", bus.dout, m_word);
                check("model_cnt", 256'(bus.dout_cnt), 256'(m_cnt));
            end
            check("model_overflow", 256'(overflow), 256'(m_ovf));
            check("model_dropped", 256'(magic_dropped), 256'(m_drop));
            if (bus.dout_valid && bus.dout_ready) xfers++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        bus.rx_wren = 1'b1;
        bus.rx_data = d;
        @(posedge clk);
        #1;
        bus.rx_wren = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Cycles until dout_valid rises, bounded.
    task automatic wait_valid(input string name, input int limit, output int n);
        n = 0;
        while (!bus.dout_valid && n < limit) begin
            tick(1);
            n++;
        end
        if (!bus.dout_valid) check({name, "_timeout"}, 256'(0), 256'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        logic [31:0] d;

        rst            = 1'b1;
        bus.rx_wren    = 1'b0;
        bus.rx_data    = '0;
        bus.dout_ready = 1'b1;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_dout", bus.dout, 256'h0);
        check("rst_cnt", 256'(bus.dout_cnt), 256'(0));
        check("rst_valid", 256'(bus.dout_valid), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));
        check("rst_dropped", 256'(magic_dropped), 256'(0));

        // Eight consecutive dwords
        for (int i = 1; i <= 8; i++) send(32'(i));
        check("seq8_valid", 256'(bus.dout_valid), 256'(1));
        check("seq8_dout", bus.dout,
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        check("seq8_cnt", 256'(bus.dout_cnt), 256'(8));
        tick(2);

        // Filler dwords are stripped
        do_reset();
        send(32'hA0000001);
        send(MAGIC);
        send(32'hB0000002);
        send(MAGIC);
        for (int i = 3; i <= 8; i++) send(32'hC0000000 | 32'(i));
        check("filter_valid", 256'(bus.dout_valid), 256'(1));
        check("filter_dout", bus.dout,
              256'hC0000008_C0000007_C0000006_C0000005_C0000004_C0000003_B0000002_A0000001);
        check("filter_dropped", 256'(magic_dropped), 256'(2));
        tick(2);

        // Idle timeout flushes a partial word padded with filler
        send(32'hAAAA0001);
        send(32'hAAAA0002);
        send(32'hAAAA0003);
        wait_valid("timeout", 200, n);
        check("timeout_latency", 256'(n), 256'(TIMEOUT));
        check("timeout_cnt", 256'(bus.dout_cnt), 256'(3));
        check("timeout_dout", bus.dout,
              256'h66665555_66665555_66665555_66665555_66665555_AAAA0003_AAAA0002_AAAA0001);
        tick(2);

        // Backpressure: two words stored, 17th dword lost
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(32'h100 + 32'(i));
        check("bp_valid", 256'(bus.dout_valid), 256'(1));
        check("bp_word1", bus.dout,
              256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
        check("bp_overflow", 256'(overflow), 256'(1));
        bus.dout_ready = 1'b1;
        tick(1);
        check("bp_word2_valid", 256'(bus.dout_valid), 256'(1));
        check("bp_word2", bus.dout,
              256'h0000010F_0000010E_0000010D_0000010C_0000010B_0000010A_00000109_00000108);
        tick(1);
        check("bp_drained", 256'(bus.dout_valid), 256'(0));
        tick(2);

        // Reset discards a partial word and clears the sticky/counter state
        send(MAGIC);
        for (int i = 0; i < 4; i++) send(32'hDEAD0000 | 32'(i));
        do_reset();
        check("rst2_overflow", 256'(overflow), 256'(0));
        check("rst2_dropped", 256'(magic_dropped), 256'(0));
        for (int i = 0; i < 8; i++) send(32'h2000 + 32'(i));
        check("rst2_dout", bus.dout,
              256'h00002007_00002006_00002005_00002004_00002003_00002002_00002001_00002000);
        check("rst2_cnt", 256'(bus.dout_cnt), 256'(8));
        tick(2);

        // Dword landing exactly on the timeout cycle cancels the flush
        send(32'hBBBB0001);
        send(32'hBBBB0002);
        tick(TIMEOUT - 1);
        send(32'hBBBB0003);
        check("tcyc_noflush", 256'(bus.dout_valid), 256'(0));
        wait_valid("tcyc", 200, n);
        check("tcyc_latency", 256'(n), 256'(TIMEOUT));
        check("tcyc_cnt", 256'(bus.dout_cnt), 256'(3));
        check("tcyc_dout", bus.dout,
              256'h66665555_66665555_66665555_66665555_66665555_BBBB0003_BBBB0002_BBBB0001);
        tick(2);

        // Randomized traffic with idle bursts, checked by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) begin
                bus.rx_wren    = 1'b0;
                bus.dout_ready = 1'b1;
                tick(TIMEOUT + 10);
            end
            bus.dout_ready = ($urandom_range(0, 9) < 7);
            bus.rx_wren    = ($urandom_range(0, 9) < 6);
            bus.rx_data    = ($urandom_range(0, 9) == 0) ? MAGIC : 32'($urandom);
            tick(1);
        end
        bus.rx_wren    = 1'b0;
        bus.dout_ready = 1'b1;
        tick(TIMEOUT + 10);

        // Sustained one dword per cycle never overflows
        do_reset();
        base = xfers;
        for (int i = 0; i < 200; i++) begin
            d = 32'($urandom);
            if (d == MAGIC) d = d ^ 32'h1;
            send(d);
        end
        tick(3);
        check("stream_overflow", 256'(overflow), 256'(0));
        check("stream_words", 256'(xfers - base), 256'(25));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
